// File: rtl/burst_mode_proc.sv
// Burst processor: collects NUM unsigned elements, then streams NUM signed results
// (prefix sum, difference from e0, ascending or descending sort). Define BURST_MODE_SAT_EN to clamp results.
module burst_mode_proc #(
  parameter int DW  = 4,
  parameter int NUM = 4,
  parameter int OW  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_number,
  input  logic [1:0]    mode,
  output logic          out_valid,
  output logic [OW-1:0] out_result,
  output logic [1:0]    dbg_state
);
  // Handshake: no ready. An element is taken on every edge that samples in_valid=1 in IDLE or IN;
  // out_valid marks a result on out_result for exactly NUM contiguous cycles, out_result is 0 otherwise.
  localparam int FW = DW + $clog2(NUM) + 1;
  localparam int CW = $clog2(NUM);
  localparam int MW = (FW > OW) ? FW : OW;

  typedef enum logic [1:0] {S_IDLE, S_IN, S_CALC, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         buf_q [NUM];
  logic [DW-1:0]         buf_d [NUM];
  logic signed [FW-1:0]  res_q [NUM];
  logic signed [FW-1:0]  res_d [NUM];

  logic                  take;
  logic [1:0]            ins_mode;
  logic [CW-1:0]         ins_n;
  logic [NUM-1:0]        gt;
  logic [NUM-1:0]        gt_prev;
  logic [DW-1:0]         ins_buf [NUM];
  logic signed [FW-1:0]  calc_res [NUM];
  logic signed [FW-1:0]  acc;

  function automatic logic signed [FW-1:0] ext(input logic [DW-1:0] x);
    return $signed({{(FW-DW){1'b0}}, x});
  endfunction

`ifdef BURST_MODE_SAT_EN
  localparam logic signed [MW-1:0] SMAX = {{(MW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [MW-1:0] SMIN = ~SMAX;
`endif

  function automatic logic [OW-1:0] reduce(input logic signed [FW-1:0] v);
    logic signed [MW-1:0] x;
    x = MW'(v);
`ifdef BURST_MODE_SAT_EN
    if (x > SMAX) return SMAX[OW-1:0];
    if (x < SMIN) return SMIN[OW-1:0];
    return x[OW-1:0];
`else
    return x[OW-1:0];
`endif
  endfunction

  // Sort modes insert into the already-ordered prefix; equal keys land after existing ones.
  assign ins_mode = (state_q == S_IDLE) ? mode : mode_q;
  assign ins_n    = (state_q == S_IDLE) ? '0 : cnt_q;
  assign gt_prev  = {gt[NUM-2:0], 1'b0};

  always_comb begin
    for (int j = 0; j < NUM; j++) begin
      gt[j] = (CW'(j) < ins_n) && (buf_q[j] > in_number);
    end
    for (int j = 0; j < NUM; j++) begin
      ins_buf[j] = in_number;
      if (ins_mode[1]) begin
        if ((CW'(j) < ins_n) && !gt[j]) ins_buf[j] = buf_q[j];
        else if (gt_prev[j])            ins_buf[j] = buf_q[(j == 0) ? 0 : j-1];
      end else if (CW'(j) != ins_n) begin
        ins_buf[j] = buf_q[j];
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NUM; i++) begin
      acc = acc + ext(buf_q[i]);
      case (mode_q)
        2'd0:    calc_res[i] = acc;
        2'd1:    calc_res[i] = ext(buf_q[i]) - ext(buf_q[0]);
        2'd2:    calc_res[i] = ext(buf_q[i]);
        default: calc_res[i] = ext(buf_q[NUM-1-i]);
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    res_d   = res_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        take    = 1'b1;
        mode_d  = mode;
        cnt_d   = CW'(1);
        state_d = S_IN;
      end
      S_IN: begin
        if (in_valid) begin
          take  = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(NUM-1)) begin
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end else begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        res_d   = calc_res;
        cnt_d   = '0;
        state_d = S_OUT;
      end
      default: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NUM-1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
    endcase
    if (take) buf_d = ins_buf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM; i++) begin
        buf_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      res_q   <= res_d;
    end
  end

  assign out_valid  = (state_q == S_OUT);
  assign out_result = (state_q == S_OUT) ? reduce(res_q[cnt_q]) : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_burst_mode_proc.sv
// Directed table-driven bench for burst_mode_proc (DW=4, NUM=4, OW=6).
module tb_burst_mode_proc;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_number;
  logic [1:0] mode;
  logic       out_valid;
  logic [5:0] out_result;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int mode;
    int e[4];
    int r[4];
    bit junk;
    bit toggle;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  burst_mode_proc #(.DW(4), .NUM(4), .OW(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_number(in_number), .mode(mode),
    .out_valid(out_valid), .out_result(out_result), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_junk(input bit junk);
    in_valid  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    in_number = 4'($urandom_range(0, 15));
    mode      = 2'($urandom_range(0, 3));
  endtask

  // Drives one burst from IDLE and checks the CALC gap and all NUM results.
  // rst_at >= 0 pulls reset low during that OUT cycle and stops there.
  task automatic run_burst(input int idx, input int rst_at);
    @(negedge clk);
    check("idle_valid", int'(out_valid), 0);
    check("idle_result", $signed(out_result), 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      in_valid  = 1'b1;
      in_number = 4'(vecs[idx].e[k]);
      mode      = 2'(vecs[idx].mode) ^ ((vecs[idx].toggle && k[0]) ? 2'b11 : 2'b00);
    end
    @(negedge clk);
    drive_junk(vecs[idx].junk);
    check("calc_valid", int'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_valid%0d", idx, i), int'(out_valid), 1);
      check($sformatf("v%0d_result%0d", idx, i), $signed(out_result), vecs[idx].r[i]);
      drive_junk(vecs[idx].junk);
      if (i == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_result", $signed(out_result), 0);
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{mode: 0, e: '{1, 2, 3, 4},     r: '{1, 3, 6, 10},   junk: 0, toggle: 0};
`ifdef BURST_MODE_SAT_EN
    vecs[1] = '{mode: 0, e: '{15, 15, 15, 15}, r: '{15, 30, 31, 31}, junk: 0, toggle: 0};
`else
    vecs[1] = '{mode: 0, e: '{15, 15, 15, 15}, r: '{15, 30, -19, -4}, junk: 0, toggle: 0};
`endif
    vecs[2] = '{mode: 1, e: '{9, 3, 15, 0},    r: '{0, -6, 6, -9},  junk: 1, toggle: 0};
    vecs[3] = '{mode: 2, e: '{7, 2, 9, 2},     r: '{2, 2, 7, 9},    junk: 1, toggle: 0};
    vecs[4] = '{mode: 3, e: '{7, 2, 9, 2},     r: '{9, 7, 2, 2},    junk: 0, toggle: 0};
    vecs[5] = '{mode: 0, e: '{1, 1, 1, 1},     r: '{1, 2, 3, 4},    junk: 0, toggle: 1};
    vecs[6] = '{mode: 2, e: '{12, 5, 3, 8},    r: '{3, 5, 8, 12},   junk: 1, toggle: 0};

    rst_n = 1'b0; in_valid = 1'b0; in_number = '0; mode = '0;
    #1;
    check("reset_valid", int'(out_valid), 0);
    check("reset_result", $signed(out_result), 0);
    check("reset_state", int'(dbg_state), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back bursts, some with junk on in_valid during CALC/OUT.
    for (int v = 0; v < 5; v++) run_burst(v, -1);

    // Abort after two elements.
    @(negedge clk);
    in_valid = 1'b1; in_number = 4'd5; mode = 2'd0;
    @(negedge clk);
    in_number = 4'd6;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("abort_valid", int'(out_valid), 0);
    end
    check("abort_state", int'(dbg_state), 0);
    run_burst(5, -1);

    // Reset during the second OUT cycle.
    run_burst(6, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_low_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_valid", int'(out_valid), 0);
    end
    check("post_rst_state", int'(dbg_state), 0);
    run_burst(0, -1);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/burst_mode_proc.md
# burst_mode_proc

Parametrised burst processor: collects a burst of `NUM` unsigned numbers, then streams `NUM` signed results computed according to a 2-bit mode. Results include prefix sum, difference from the first element, and ascending or descending sort. It generalises the single-result lab06 arithmetic block in input width, burst length, result width and mode set. It sits between the pattern driver and the checker, using the same `in_valid`/`out_valid` handshake.

## Interface
- `DW`, 4, input element width (unsigned)
- `NUM`, 4, elements per burst (≥2)
- `OW`, 6, output result width (signed, two's complement)
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous active-low reset
- `in_valid` input 1 — element present on `in_number`
- `in_number` input DW — unsigned element
- `mode` input 2 — operation select; sampled only on the first `in_valid` cycle of a burst
- `out_valid` output 1 — result present on `out_result`
- `out_result` output OW — signed result; 0 whenever `out_valid` = 0

## Operation
- Internal full-precision width `FW = DW + $clog2(NUM) + 1`, signed; all arithmetic is done at FW, then reduced to OW at output.
- FSM states:
  - IDLE → IN on `in_valid`. Latch `mode` and element 0.
  - IN: store one element per cycle. After the NUM-th element → CALC. If `in_valid` = 0 before NUM elements are taken: discard the burst and go to IDLE with no output.
  - CALC: one cycle to finalise results → OUT.
  - OUT: emit NUM results on consecutive cycles, index 0 first → IDLE.
- Modes (elements e0..e(NUM-1) in arrival order):
  - 0: prefix sum; r_i = e0+…+ei.
  - 1: difference; r_i = ei − e0, so r_0 = 0.
  - 2: ascending sort; r_i = i-th smallest element. Stable; equal values are allowed.
  - 3: descending sort; r_i = i-th largest element.
- Sorting is insertion-on-arrival into a NUM-entry buffer, one insertion per IN cycle. No extra latency.
- `in_valid` during CALC or OUT is ignored. A new burst is accepted only from IDLE.
- Reset value of every output and all state: `out_valid` = 0, `out_result` = 0, FSM = IDLE, buffer cleared.

## Timing
- Element k sampled at edge t0+k, for k = 0..NUM-1.
- CALC is the cycle after edge t0+NUM-1.
- `out_valid` = 1 from the cycle after edge t0+NUM through edge t0+2·NUM. Exactly NUM contiguous cycles.
- Latency from last element sample to first result: 2 edges.
- `in_valid` may re-assert in the cycle after the last `out_valid`. The new burst's first element is sampled on that edge.
- Reset asserted mid-burst or mid-OUT: outputs go to 0 immediately (asynchronous) and any partial burst is lost. After release, the block waits in IDLE.
- Burst abort (`in_valid` drop) takes effect on the edge where `in_valid` = 0 is sampled. `out_valid` never rises for that burst.

## Configuration
- `BURST_MODE_SAT_EN` defined: the FW result is clamped to [−2^(OW−1), 2^(OW−1)−1] before output.
- Not defined: `out_result` is the low OW bits of the FW result (two's-complement wrap).
- When FW ≤ OW both builds behave identically.

## Test plan
All scenarios use DW=4, NUM=4, OW=6.
- Mode 0, inputs 1,2,3,4 → `out_valid` 4 cycles, results 1,3,6,10. First result 2 edges after the last input.
- Mode 0, inputs 15,15,15,15 → without macro: 15,30,−19,−4. With `BURST_MODE_SAT_EN`: 15,30,31,31.
- Mode 1, inputs 9,3,15,0 → 0,−6,6,−9. Mode 2, inputs 7,2,9,2 → 2,2,7,9. Mode 3, same inputs → 9,7,2,2.
- Abort: `in_valid` high for 2 cycles, then low → `out_valid` stays 0. Next full mode-0 burst 1,1,1,1 → 1,2,3,4. `mode` toggled after the first element is ignored.
- `in_valid` driven with junk during CALC/OUT → outputs unaffected. A burst starting the cycle after the last result is accepted back-to-back.
- `rst_n` pulsed low during the 2nd OUT cycle → `out_valid`/`out_result` 0 immediately, no further results. The next burst behaves normally.
